// File: rtl/rename_rat_pkg.sv
// Shared constants for the rename stage and its alias tables.
// Optional build macro: RENAME_R0_ZERO_EN (hard-wires logical r0 to PR 0).
package rename_rat_pkg;

    localparam int DEF_P_ISSUE_WIDTH  = 1;
    localparam int DEF_P_COMMIT_WIDTH = 1;
    localparam int NCPU_PRF_AW        = 6;
    localparam int NCPU_LRF_AW        = 5;
    localparam int R0_IDX             = 0;

endpackage

// File: rtl/rat_table.sv
// Register alias table: flop array reset to identity, multi-port read,
// prioritized writes (highest port wins) and a whole-table load.
module rat_table #(
    parameter int LRF_AW = 5,
    parameter int PRF_AW = 6,
    parameter int NR     = 1,
    parameter int NW     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NR*LRF_AW-1:0]          rd_addr_i,
    output logic [NR*PRF_AW-1:0]          rd_data_o,
    input  logic [NW-1:0]                 we_i,
    input  logic [NW*LRF_AW-1:0]          wr_addr_i,
    input  logic [NW*PRF_AW-1:0]          wr_data_i,
    input  logic                          load_i,
    input  logic [(1<<LRF_AW)*PRF_AW-1:0] load_data_i,
    output logic [(1<<LRF_AW)*PRF_AW-1:0] next_o
);

    localparam int N_LRF = 1 << LRF_AW;

    logic [PRF_AW-1:0] tbl_q [N_LRF];
    logic [PRF_AW-1:0] tbl_d [N_LRF];

    // Later write ports override earlier ones; a load overrides all writes.
    always_comb begin
        for (int i = 0; i < N_LRF; i++) begin
            tbl_d[i] = tbl_q[i];
        end
        for (int w = 0; w < NW; w++) begin
            if (we_i[w]) begin
                tbl_d[wr_addr_i[w*LRF_AW +: LRF_AW]] = wr_data_i[w*PRF_AW +: PRF_AW];
            end
        end
        if (load_i) begin
            for (int i = 0; i < N_LRF; i++) begin
                tbl_d[i] = load_data_i[i*PRF_AW +: PRF_AW];
            end
        end
    end

    always_comb begin
        next_o = '0;
        for (int i = 0; i < N_LRF; i++) begin
            next_o[i*PRF_AW +: PRF_AW] = tbl_d[i];
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < NR; r++) begin
            rd_data_o[r*PRF_AW +: PRF_AW] = tbl_q[rd_addr_i[r*LRF_AW +: LRF_AW]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LRF; i++) begin
                tbl_q[i] <= PRF_AW'(i);
            end
        end else begin
            for (int i = 0; i < N_LRF; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

endmodule

// File: rtl/rename_rat.sv
// Rename stage: maps a decode group through the speculative RAT, pops free PRs,
// tracks the architectural RAT at commit. Optional macro: RENAME_R0_ZERO_EN.
module rename_rat
    import rename_rat_pkg::*;
#(
    parameter int CONFIG_P_ISSUE_WIDTH  = DEF_P_ISSUE_WIDTH,
    parameter int CONFIG_P_COMMIT_WIDTH = DEF_P_COMMIT_WIDTH,
    parameter int CONFIG_PRF_AW         = NCPU_PRF_AW,
    parameter int CONFIG_LRF_AW         = NCPU_LRF_AW,
    localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH,
    localparam int PA = CONFIG_PRF_AW,
    localparam int LA = CONFIG_LRF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rollback_i,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [IW*LA-1:0] id_lrs1_i,
    input  logic [IW*LA-1:0] id_lrs2_i,
    input  logic [IW*LA-1:0] id_lrd_i,
    input  logic [IW-1:0]    id_lrd_we_i,
    output logic             fl_pop_o,
    output logic [IW-1:0]    fl_lrd_we_o,
    input  logic [IW*PA-1:0] fl_prd_i,
    input  logic             fl_stall_req_i,
    output logic             rn_valid_o,
    input  logic             rn_ready_i,
    output logic [IW*PA-1:0] rn_prs1_o,
    output logic [IW*PA-1:0] rn_prs2_o,
    output logic [IW*PA-1:0] rn_prd_o,
    output logic [IW*PA-1:0] rn_pfree_o,
    output logic [IW-1:0]    rn_prd_we_o,
    input  logic [CW-1:0]    commit_fl_push_i,
    input  logic [CW*LA-1:0] commit_lrd_i,
    input  logic [CW*PA-1:0] commit_prd_i,
    input  logic [CW-1:0]    commit_prd_we_i
);

    localparam int N_LRF = 1 << LA;

    logic                 fire;
    logic [IW-1:0]        dstWe;
    logic [CW-1:0]        commitWe;
    logic [3*IW*LA-1:0]   sratRdAddr;
    logic [3*IW*PA-1:0]   sratRdData;
    logic [N_LRF*PA-1:0]  aratNext;
    logic [N_LRF*PA-1:0]  sratNext;
    logic [PA-1:0]        aratRdData;
    logic                 unusedBits;

    logic [IW*PA-1:0] prs1, prs2, pfree, prdOut;

    logic             rnValid_q,   rnValid_d;
    logic [IW*PA-1:0] rnPrs1_q,    rnPrs1_d;
    logic [IW*PA-1:0] rnPrs2_q,    rnPrs2_d;
    logic [IW*PA-1:0] rnPrd_q,     rnPrd_d;
    logic [IW*PA-1:0] rnPfree_q,   rnPfree_d;
    logic [IW-1:0]    rnPrdWe_q,   rnPrdWe_d;

    assign id_ready_o  = (~rnValid_q | rn_ready_i) & ~fl_stall_req_i & ~rollback_i;
    assign fire        = id_valid_i & id_ready_o;
    assign fl_pop_o    = fire;
    assign fl_lrd_we_o = dstWe & {IW{id_valid_i}};

    // With r0 hard-wired, a destination of r0 is simply not a destination.
    always_comb begin
        for (int j = 0; j < IW; j++) begin
`ifdef RENAME_R0_ZERO_EN
            dstWe[j] = id_lrd_we_i[j] & (id_lrd_i[j*LA +: LA] != LA'(R0_IDX));
`else
            dstWe[j] = id_lrd_we_i[j];
`endif
        end
        for (int c = 0; c < CW; c++) begin
`ifdef RENAME_R0_ZERO_EN
            commitWe[c] = commit_fl_push_i[c] & commit_prd_we_i[c] &
                          (commit_lrd_i[c*LA +: LA] != LA'(R0_IDX));
`else
            commitWe[c] = commit_fl_push_i[c] & commit_prd_we_i[c];
`endif
        end
    end

    always_comb begin
        for (int j = 0; j < IW; j++) begin
            sratRdAddr[(3*j+0)*LA +: LA] = id_lrs1_i[j*LA +: LA];
            sratRdAddr[(3*j+1)*LA +: LA] = id_lrs2_i[j*LA +: LA];
            sratRdAddr[(3*j+2)*LA +: LA] = id_lrd_i[j*LA +: LA];
        end
    end

    rat_table #(.LRF_AW(LA), .PRF_AW(PA), .NR(3*IW), .NW(IW)) u_srat (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (sratRdAddr),
        .rd_data_o   (sratRdData),
        .we_i        (dstWe & {IW{fire}}),
        .wr_addr_i   (id_lrd_i),
        .wr_data_i   (fl_prd_i),
        .load_i      (rollback_i),
        .load_data_i (aratNext),
        .next_o      (sratNext)
    );

    rat_table #(.LRF_AW(LA), .PRF_AW(PA), .NR(1), .NW(CW)) u_arat (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   ('0),
        .rd_data_o   (aratRdData),
        .we_i        (commitWe),
        .wr_addr_i   (commit_lrd_i),
        .wr_data_i   (commit_prd_i),
        .load_i      (1'b0),
        .load_data_i ('0),
        .next_o      (aratNext)
    );

    assign unusedBits = ^{sratNext, aratRdData};

    // Intra-group bypass: the latest earlier slot writing the same register wins.
    always_comb begin
        for (int j = 0; j < IW; j++) begin
            prs1[j*PA +: PA]  = sratRdData[(3*j+0)*PA +: PA];
            prs2[j*PA +: PA]  = sratRdData[(3*j+1)*PA +: PA];
            pfree[j*PA +: PA] = sratRdData[(3*j+2)*PA +: PA];
            for (int k = 0; k < IW; k++) begin
                if (k < j && dstWe[k]) begin
                    if (id_lrd_i[k*LA +: LA] == id_lrs1_i[j*LA +: LA])
                        prs1[j*PA +: PA] = fl_prd_i[k*PA +: PA];
                    if (id_lrd_i[k*LA +: LA] == id_lrs2_i[j*LA +: LA])
                        prs2[j*PA +: PA] = fl_prd_i[k*PA +: PA];
                    if (id_lrd_i[k*LA +: LA] == id_lrd_i[j*LA +: LA])
                        pfree[j*PA +: PA] = fl_prd_i[k*PA +: PA];
                end
            end
`ifdef RENAME_R0_ZERO_EN
            if (id_lrs1_i[j*LA +: LA] == LA'(R0_IDX)) prs1[j*PA +: PA] = '0;
            if (id_lrs2_i[j*LA +: LA] == LA'(R0_IDX)) prs2[j*PA +: PA] = '0;
`endif
            if (!dstWe[j]) pfree[j*PA +: PA] = '0;
            prdOut[j*PA +: PA] = dstWe[j] ? fl_prd_i[j*PA +: PA] : '0;
        end
    end

    always_comb begin
        rnValid_d = rnValid_q;
        rnPrs1_d  = rnPrs1_q;
        rnPrs2_d  = rnPrs2_q;
        rnPrd_d   = rnPrd_q;
        rnPfree_d = rnPfree_q;
        rnPrdWe_d = rnPrdWe_q;
        if (rollback_i) begin
            rnValid_d = 1'b0;
        end else if (fire) begin
            rnValid_d = 1'b1;
            rnPrs1_d  = prs1;
            rnPrs2_d  = prs2;
            rnPrd_d   = prdOut;
            rnPfree_d = pfree;
            rnPrdWe_d = dstWe;
        end else if (rn_ready_i) begin
            rnValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnValid_q <= 1'b0;
            rnPrs1_q  <= '0;
            rnPrs2_q  <= '0;
            rnPrd_q   <= '0;
            rnPfree_q <= '0;
            rnPrdWe_q <= '0;
        end else begin
            rnValid_q <= rnValid_d;
            rnPrs1_q  <= rnPrs1_d;
            rnPrs2_q  <= rnPrs2_d;
            rnPrd_q   <= rnPrd_d;
            rnPfree_q <= rnPfree_d;
            rnPrdWe_q <= rnPrdWe_d;
        end
    end

    assign rn_valid_o  = rnValid_q;
    assign rn_prs1_o   = rnPrs1_q;
    assign rn_prs2_o   = rnPrs2_q;
    assign rn_prd_o    = rnPrd_q;
    assign rn_pfree_o  = rnPfree_q;
    assign rn_prd_we_o = rnPrdWe_q;

endmodule

// File: tb/tb_rename_rat.sv
// Bench for rename_rat (IW=2, CW=2): sequential-walk RAT model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_rename_rat;

    logic        clk;
    logic        rst;
    logic        rollback;
    logic        idValid;
    logic        idReady;
    logic [9:0]  lrs1, lrs2, lrd;
    logic [1:0]  lrdWe;
    logic        flPop;
    logic [1:0]  flLrdWe;
    logic [11:0] flPrd;
    logic        flStall;
    logic        rnValid;
    logic        rnReady;
    logic [11:0] rnPrs1, rnPrs2, rnPrd, rnPfree;
    logic [1:0]  rnPrdWe;
    logic [1:0]  cPush, cWe;
    logic [9:0]  cLrd;
    logic [11:0] cPrd;

    int vecCount  = 0;
    int missCount = 0;

    // Reference state: plain arrays updated by walking the group slot by slot.
    logic [5:0] mSrat [32];
    logic [5:0] mArat [32];
    logic       mValid;
    logic [5:0] mPrs1 [2], mPrs2 [2], mPrd [2], mPfree [2];
    logic       mPrdWe [2];

    rename_rat dut (
        .clk              (clk),
        .rst              (rst),
        .rollback_i       (rollback),
        .id_valid_i       (idValid),
        .id_ready_o       (idReady),
        .id_lrs1_i        (lrs1),
        .id_lrs2_i        (lrs2),
        .id_lrd_i         (lrd),
        .id_lrd_we_i      (lrdWe),
        .fl_pop_o         (flPop),
        .fl_lrd_we_o      (flLrdWe),
        .fl_prd_i         (flPrd),
        .fl_stall_req_i   (flStall),
        .rn_valid_o       (rnValid),
        .rn_ready_i       (rnReady),
        .rn_prs1_o        (rnPrs1),
        .rn_prs2_o        (rnPrs2),
        .rn_prd_o         (rnPrd),
        .rn_pfree_o       (rnPfree),
        .rn_prd_we_o      (rnPrdWe),
        .commit_fl_push_i (cPush),
        .commit_lrd_i     (cLrd),
        .commit_prd_i     (cPrd),
        .commit_prd_we_i  (cWe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic isDst(input logic we, input logic [4:0] r);
`ifdef RENAME_R0_ZERO_EN
        return we && (r != 5'd0);
`else
        return we;
`endif
    endfunction

    function automatic logic [5:0] look(input logic [5:0] v, input logic [4:0] r);
`ifdef RENAME_R0_ZERO_EN
        if (r == 5'd0) return 6'd0;
`endif
        return v;
    endfunction

    function automatic logic expReady();
        return (!mValid || rnReady) && !flStall && !rollback;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mSrat[i] = 6'(i);
                mArat[i] = 6'(i);
            end
            mValid = 1'b0;
            for (int j = 0; j < 2; j++) begin
                mPrs1[j] = '0; mPrs2[j] = '0; mPrd[j] = '0; mPfree[j] = '0; mPrdWe[j] = 1'b0;
            end
        end else begin
            if (idValid && expReady()) begin
                for (int j = 0; j < 2; j++) begin
                    logic [4:0] d;
                    d = lrd[j*5 +: 5];
                    mPrs1[j]  = look(mSrat[lrs1[j*5 +: 5]], lrs1[j*5 +: 5]);
                    mPrs2[j]  = look(mSrat[lrs2[j*5 +: 5]], lrs2[j*5 +: 5]);
                    mPrdWe[j] = isDst(lrdWe[j], d);
                    mPfree[j] = mPrdWe[j] ? mSrat[d] : 6'd0;
                    mPrd[j]   = flPrd[j*6 +: 6];
                    if (mPrdWe[j]) mSrat[d] = flPrd[j*6 +: 6];
                end
                mValid = 1'b1;
            end else if (rnReady) begin
                mValid = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                if (cPush[c] && isDst(cWe[c], cLrd[c*5 +: 5]))
                    mArat[cLrd[c*5 +: 5]] = cPrd[c*6 +: 6];
            end
            if (rollback) begin
                for (int i = 0; i < 32; i++) mSrat[i] = mArat[i];
                mValid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("id_ready", 32'(idReady), 32'(expReady()));
            checkOutput("fl_pop", 32'(flPop), 32'(idValid && expReady()));
            checkOutput("fl_lrd_we", 32'(flLrdWe),
                        32'({isDst(lrdWe[1], lrd[9:5]), isDst(lrdWe[0], lrd[4:0])} & {2{idValid}}));
            checkOutput("rn_valid", 32'(rnValid), 32'(mValid));
            if (mValid) begin
                for (int j = 0; j < 2; j++) begin
                    checkOutput("rn_prs1", 32'(rnPrs1[j*6 +: 6]), 32'(mPrs1[j]));
                    checkOutput("rn_prs2", 32'(rnPrs2[j*6 +: 6]), 32'(mPrs2[j]));
                    checkOutput("rn_pfree", 32'(rnPfree[j*6 +: 6]), 32'(mPfree[j]));
                    checkOutput("rn_prd_we", 32'(rnPrdWe[j]), 32'(mPrdWe[j]));
                    if (mPrdWe[j]) checkOutput("rn_prd", 32'(rnPrd[j*6 +: 6]), 32'(mPrd[j]));
                end
            end
        end
    end

    task automatic applyStimulus(input logic v,
                                 input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                                 input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd,
                                 input logic [1:0] w, input logic [5:0] pa, input logic [5:0] pb);
        idValid = v;
        lrs1    = {b1, a1};
        lrs2    = {b2, a2};
        lrd     = {bd, ad};
        lrdWe   = w;
        flPrd   = {pb, pa};
    endtask

    task automatic setCommit(input logic [1:0] p, input logic [4:0] l0, input logic [5:0] p0,
                             input logic [4:0] l1, input logic [5:0] p1);
        cPush = p;
        cWe   = p;
        cLrd  = {l1, l0};
        cPrd  = {p1, p0};
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rollback = 1'b0; flStall = 1'b0; rnReady = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        setCommit(2'b00, 0, 0, 0, 0);
        repeat (2) stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("reset rn_valid", 32'(rnValid), 0);
        checkOutput("reset rn_prs1", 32'(rnPrs1), 0);
        checkOutput("reset rn_pfree", 32'(rnPfree), 0);
        checkOutput("reset id_ready", 32'(idReady), 1);
        stepCycle();

        // Sources only, straight from the identity map.
        applyStimulus(1, 3, 4, 0, 0, 0, 0, 2'b00, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        checkOutput("t1 rn_valid", 32'(rnValid), 1);
        checkOutput("t1 prs1", 32'(rnPrs1[5:0]), 3);
        checkOutput("t1 prs2", 32'(rnPrs2[5:0]), 4);

        // Same-group dependency on r5.
        applyStimulus(1, 0, 0, 5, 5, 0, 5, 2'b11, 40, 41);
        stepCycle();
        checkOutput("t2 s1 prs1", 32'(rnPrs1[11:6]), 40);
        checkOutput("t2 s0 pfree", 32'(rnPfree[5:0]), 5);
        checkOutput("t2 s1 pfree", 32'(rnPfree[11:6]), 40);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        stepCycle();
        checkOutput("t2 srat5", 32'(rnPrs1[5:0]), 41);

        // Free-list stall blocks the group entirely.
        flStall = 1'b1;
        applyStimulus(1, 0, 0, 6, 0, 0, 0, 2'b01, 45, 0);
        #1;
        checkOutput("stall id_ready", 32'(idReady), 0);
        checkOutput("stall fl_pop", 32'(flPop), 0);
        stepCycle();
        checkOutput("stall drain", 32'(rnValid), 0);
        flStall = 1'b0;
        #1;
        checkOutput("release fl_pop", 32'(flPop), 1);
        stepCycle();
        checkOutput("release rn_valid", 32'(rnValid), 1);
        checkOutput("release pfree", 32'(rnPfree[5:0]), 6);

        // Downstream backpressure holds the output register.
        rnReady = 1'b0;
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp id_ready", 32'(idReady), 0);
            stepCycle();
            checkOutput("bp pfree hold", 32'(rnPfree[5:0]), 6);
            checkOutput("bp prd hold", 32'(rnPrd[5:0]), 45);
        end
        rnReady = 1'b1;
        #1;
        checkOutput("bp release ready", 32'(idReady), 1);
        stepCycle();
        checkOutput("bp new group", 32'(rnPrs1[5:0]), 9);

        // Commit, speculate past it, then roll back with a same-cycle commit.
        applyStimulus(1, 0, 0, 7, 0, 0, 0, 2'b01, 50, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        setCommit(2'b01, 7, 50, 0, 0);
        stepCycle();
        setCommit(2'b00, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 7, 0, 0, 0, 2'b01, 51, 0);
        stepCycle();
        checkOutput("rb pre pfree", 32'(rnPfree[5:0]), 50);
        rollback = 1'b1;
        setCommit(2'b10, 0, 0, 8, 52);
        applyStimulus(1, 0, 0, 10, 0, 0, 0, 2'b01, 60, 0);
        #1;
        checkOutput("rb fl_pop", 32'(flPop), 0);
        stepCycle();
        checkOutput("rb rn_valid", 32'(rnValid), 0);
        rollback = 1'b0;
        setCommit(2'b00, 0, 0, 0, 0);
        applyStimulus(1, 7, 8, 0, 10, 0, 0, 2'b00, 0, 0);
        stepCycle();
        checkOutput("rb srat7", 32'(rnPrs1[5:0]), 50);
        checkOutput("rb srat8", 32'(rnPrs2[5:0]), 52);
        checkOutput("rb srat10", 32'(rnPrs1[11:6]), 10);

        // Asynchronous reset mid-operation.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        rst = 1'b1;
        #1;
        checkOutput("async rst valid", 32'(rnValid), 0);
        checkOutput("async rst prs1", 32'(rnPrs1), 0);
        stepCycle();
        rst = 1'b0;
        applyStimulus(1, 7, 8, 0, 0, 0, 0, 2'b00, 0, 0);
        stepCycle();
        checkOutput("post rst r7", 32'(rnPrs1[5:0]), 7);
        checkOutput("post rst r8", 32'(rnPrs2[5:0]), 8);

`ifdef RENAME_R0_ZERO_EN
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b01, 33, 0);
        #1;
        checkOutput("r0 fl_lrd_we", 32'(flLrdWe), 0);
        stepCycle();
        checkOutput("r0 prd_we", 32'(rnPrdWe), 0);
        checkOutput("r0 pfree", 32'(rnPfree[5:0]), 0);
        checkOutput("r0 read", 32'(rnPrs1[11:6]), 0);
`endif

        // Mixed traffic with overlapping registers, commits and flushes.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                          5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                          2'($urandom_range(0, 3)), 6'($urandom_range(32, 63)), 6'($urandom_range(32, 63)));
            setCommit(2'($urandom_range(0, 3)), 5'($urandom_range(0, 6)), 6'($urandom_range(32, 63)),
                      5'($urandom_range(0, 6)), 6'($urandom_range(32, 63)));
            rnReady  = 1'($urandom_range(0, 2) != 0);
            flStall  = 1'($urandom_range(0, 4) == 0);
            rollback = 1'($urandom_range(0, 7) == 0);
            stepCycle();
        end
        rollback = 1'b0;
        flStall  = 1'b0;
        rnReady  = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        setCommit(2'b00, 0, 0, 0, 0);
        repeat (2) stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
